wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single integer/FP register-file write port between three sources:
  - the in-order pipeline writeback (WB stage output);
  - scalar results returned by the VPU (e.g. vmv.x.s, vfmv.f.s, vsetvl rd);
  - the long-latency iterative unit (div/rem, fdiv/fsqrt).
- Sits between the WB stage and the register files and replaces the direct WB-to-regfile write connection.
- The pipeline has priority; the two secondary sources are buffered and served round-robin.
- A starvation counter forces a one-cycle pipeline stall so secondary results always drain.

Parameters:
- QDEPTH, 2, entries per secondary-source queue (power of two, >=2)
- STARVE_LIMIT, 8, consecutive cycles a non-empty queue may be denied before a stall is forced
- PTR_W, $clog2(QDEPTH), queue pointer width (derived)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- pipe_valid_i  in  1  WB stage wants the port this cycle (wb_rd_web | wb_frd_web)
- pipe_fpr_i  in  1  pipeline target is FP register file
- pipe_rd_i  in  5  pipeline destination register
- pipe_data_i  in  32  pipeline write data
- vpu_valid_i  in  1  VPU scalar result valid
- vpu_ready_o  out  1  VPU queue not full
- vpu_fpr_i  in  1  VPU target is FP register file
- vpu_rd_i  in  5  VPU destination register
- vpu_data_i  in  32  VPU result
- ll_valid_i  in  1  long-latency unit result valid
- ll_ready_o  out  1  long-latency queue not full
- ll_fpr_i  in  1  long-latency target is FP register file
- ll_rd_i  in  5  long-latency destination register
- ll_data_i  in  32  long-latency result
- stall_o  out  1  request pipeline freeze for this cycle (WB instruction re-presented next cycle)
- rd_web_o  out  1  integer regfile write enable
- frd_web_o  out  1  FP regfile write enable
- rd_o  out  5  write address
- data_o  out  32  write data
- ll_pending_o  out  1  either queue non-empty (used by WFI/trap logic to delay until drained)

Behaviour:
- Reset (synchronous, active-high): queues empty, pointers 0, round-robin pointer selects VPU, starvation counter 0.
  - All outputs 0, except vpu_ready_o=1 and ll_ready_o=1.
- Enqueue:
  - Push on valid_i & ready_o; ready_o = !full.
  - Push and pop in the same cycle on a full queue is NOT allowed (ready_o depends only on registered full). No combinational path from valid_i to ready_o.
  - valid_i held with ready_o=0 must keep its payload stable.
- Port selection (combinational, zero latency from pipe inputs):
  1. stall_o=1: the port goes to the round-robin winner among non-empty queues; pipe_valid_i is ignored.
  2. Else pipe_valid_i=1: the pipeline write passes straight through; no pop.
  3. Else, if any queue is non-empty: the round-robin winner's head is written and popped this cycle.
  4. Else: no write.
- Write enables:
  - rd_web_o = sel_valid & !fpr & (rd!=0).
  - frd_web_o = sel_valid & fpr.
  - A popped integer entry with rd=0 is still popped and discarded.
- Round-robin:
  - After a pop from source S, priority goes to the other source.
  - If only one queue is non-empty, it wins regardless of the pointer.
- Starvation counter:
  - Increments each cycle in which a queue is non-empty and case 2 wins.
  - Clears on any pop, or when both queues are empty.
  - Saturates at STARVE_LIMIT.
- stall_o = (counter==STARVE_LIMIT) & (any queue non-empty).
  - Purely registered-state based; asserted for exactly one cycle, since the pop clears the counter.
- ll_pending_o = !empty_vpu | !empty_ll.
- Ordering precondition: the issue scoreboard guarantees no WAW/RAW between a pipeline write and an outstanding queued rd. An SVA assertion flags pipe_valid_i with pipe_rd_i equal to any queued rd of the same file.
- Within one queue, writes retire in FIFO order.
- Reset mid-operation: queued results are discarded; producers must also be reset.

Decomposition:
- Shared package entry: wb_req_t struct {fpr, rd[4:0], data[31:0]} and the enum WB_SRC_t {PIPE, VPU, LL}.
- One sub-module: wb_req_fifo (parameterised depth, push/pop/full/empty/head), instantiated twice.
- Arbitration and the starvation counter live in the top module.

Test Plan:
- After reset, idle -> all write outputs 0, vpu_ready_o=ll_ready_o=1, stall_o=0, ll_pending_o=0.
- ll push {fpr=0, rd=5, data=0x1234} with pipe idle -> next cycle rd_web_o=1, rd_o=5, data_o=0x1234; queue empty the cycle after.
- VPU and LL push the same cycle, pipe idle -> two consecutive writes VPU then LL; a second simultaneous pair is served LL then VPU.
- pipe_valid_i held 1 for 20 cycles with an LL entry queued (STARVE_LIMIT=8) -> stall_o=1 on exactly the 9th cycle, with the LL entry written that cycle; pipe writes on all other cycles.
- Fill the VPU queue (2 pushes, pipe busy) -> vpu_ready_o=0, a third valid is held and not lost, ready rises the cycle after a pop.
- LL entry {fpr=0, rd=0}, then {fpr=1, rd=0, data=0xDEAD} -> first popped with no write enable; second gives frd_web_o=1, rd_o=0, data_o=0xDEAD.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: the write request
// record, the source encoding and the round-robin pick helper.
package wb_port_arbiter_pkg;

    localparam int unsigned WB_RD_W   = 5;
    localparam int unsigned WB_DATA_W = 32;

    typedef struct packed {
        logic                 fpr;
        logic [WB_RD_W-1:0]   rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    localparam int unsigned WB_REQ_W = $bits(wb_req_t);

    typedef enum logic [1:0] {
        PIPE = 2'd0,
        VPU  = 2'd1,
        LL   = 2'd2
    } WB_SRC_t;

    // A lone non-empty queue wins outright; the pointer only breaks ties.
    // PIPE is returned when both are empty and must be gated by the caller.
    function automatic WB_SRC_t rr_pick(input logic vpu_ne, input logic ll_ne,
                                        input WB_SRC_t pref);
        if (vpu_ne && ll_ne) begin
            return pref;
        end else if (vpu_ne) begin
            return VPU;
        end else if (ll_ne) begin
            return LL;
        end else begin
            return PIPE;
        end
    endfunction

endpackage

// File: rtl/wb_port_arbiter_chk.sv
// Flags a pipeline write that targets a register still waiting in either
// secondary queue; the issue scoreboard is expected to prevent this.
module wb_port_arbiter_chk
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned QDEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pipe_valid,
    input  logic                 pipe_fpr,
    input  logic [WB_RD_W-1:0]   pipe_rd,
    input  wb_req_t [QDEPTH-1:0] vpu_slots,
    input  logic    [QDEPTH-1:0] vpu_slot_vld,
    input  wb_req_t [QDEPTH-1:0] ll_slots,
    input  logic    [QDEPTH-1:0] ll_slot_vld
);

    logic hazard_s;

    // Match the pipeline target against every live queued destination
    always_comb begin
        hazard_s = 1'b0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            hazard_s = hazard_s
                     | (vpu_slot_vld[i] & (vpu_slots[i].fpr == pipe_fpr) & (vpu_slots[i].rd == pipe_rd))
                     | (ll_slot_vld[i]  & (ll_slots[i].fpr  == pipe_fpr) & (ll_slots[i].rd  == pipe_rd));
        end
    end

    a_no_pipe_queue_hazard: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pipe_valid && hazard_s));

endmodule

// File: rtl/wb_req_fifo.sv
// Small circular FIFO of write requests; full/empty come only from registered
// occupancy so ready never depends combinationally on the producer's valid.
module wb_req_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned PTR_W  = $clog2(QDEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  wb_req_t                push_req,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output wb_req_t                head,
    output wb_req_t [QDEPTH-1:0]   slots,
    output logic    [QDEPTH-1:0]   slot_vld
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(QDEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    wb_req_t [QDEPTH-1:0] mem_r;
    logic    [PTR_W-1:0]  wr_ptr_r;
    logic    [PTR_W-1:0]  rd_ptr_r;
    logic    [PTR_W:0]    count_r;
    logic                 push_s;
    logic                 pop_s;

    assign full   = (count_r == FULL_CNT);
    assign empty  = (count_r == {(PTR_W+1){1'b0}});
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;
    assign head   = mem_r[rd_ptr_r];
    assign slots  = mem_r;

    // Storage, pointers and occupancy update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_r    <= {(QDEPTH*WB_REQ_W){1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_req;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below occupancy
    always_comb begin
        slot_vld = {QDEPTH{1'b0}};
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            slot_vld[i] = ({1'b0, PTR_W'(i) - rd_ptr_r} < count_r);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline writeback and two
// buffered secondary sources (VPU scalar results, long-latency unit).
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned QDEPTH       = 2,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned PTR_W        = $clog2(QDEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pipe_valid_i,
    input  logic        pipe_fpr_i,
    input  logic [4:0]  pipe_rd_i,
    input  logic [31:0] pipe_data_i,
    input  logic        vpu_valid_i,
    output logic        vpu_ready_o,
    input  logic        vpu_fpr_i,
    input  logic [4:0]  vpu_rd_i,
    input  logic [31:0] vpu_data_i,
    input  logic        ll_valid_i,
    output logic        ll_ready_o,
    input  logic        ll_fpr_i,
    input  logic [4:0]  ll_rd_i,
    input  logic [31:0] ll_data_i,
    output logic        stall_o,
    output logic        rd_web_o,
    output logic        frd_web_o,
    output logic [4:0]  rd_o,
    output logic [31:0] data_o,
    output logic        ll_pending_o
);

    localparam int unsigned     CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    wb_req_t                vpu_push_req_s;
    wb_req_t                ll_push_req_s;
    wb_req_t                vpu_head_s;
    wb_req_t                ll_head_s;
    wb_req_t                head_sel_s;
    wb_req_t                sel_req_s;
    wb_req_t [QDEPTH-1:0]   vpu_slots_s;
    wb_req_t [QDEPTH-1:0]   ll_slots_s;
    logic    [QDEPTH-1:0]   vpu_slot_vld_s;
    logic    [QDEPTH-1:0]   ll_slot_vld_s;
    logic                   vpu_full_s;
    logic                   vpu_empty_s;
    logic                   ll_full_s;
    logic                   ll_empty_s;
    logic                   vpu_push_s;
    logic                   ll_push_s;
    logic                   vpu_pop_s;
    logic                   ll_pop_s;
    logic                   any_q_s;
    logic                   pop_s;
    logic                   sel_valid_s;
    logic                   stall_s;
    WB_SRC_t                winner_s;
    WB_SRC_t                rr_r;
    logic    [CNT_W-1:0]    starve_cnt_r;

    assign vpu_push_req_s = '{fpr: vpu_fpr_i, rd: vpu_rd_i, data: vpu_data_i};
    assign ll_push_req_s  = '{fpr: ll_fpr_i,  rd: ll_rd_i,  data: ll_data_i};
    assign vpu_ready_o    = ~vpu_full_s;
    assign ll_ready_o     = ~ll_full_s;
    assign vpu_push_s     = vpu_valid_i & vpu_ready_o;
    assign ll_push_s      = ll_valid_i & ll_ready_o;

    wb_req_fifo #(.QDEPTH(QDEPTH), .PTR_W(PTR_W)) u_vpu_q (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (vpu_push_s),
        .push_req (vpu_push_req_s),
        .pop      (vpu_pop_s),
        .full     (vpu_full_s),
        .empty    (vpu_empty_s),
        .head     (vpu_head_s),
        .slots    (vpu_slots_s),
        .slot_vld (vpu_slot_vld_s)
    );

    wb_req_fifo #(.QDEPTH(QDEPTH), .PTR_W(PTR_W)) u_ll_q (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (ll_push_s),
        .push_req (ll_push_req_s),
        .pop      (ll_pop_s),
        .full     (ll_full_s),
        .empty    (ll_empty_s),
        .head     (ll_head_s),
        .slots    (ll_slots_s),
        .slot_vld (ll_slot_vld_s)
    );

    assign any_q_s    = ~vpu_empty_s | ~ll_empty_s;
    assign winner_s   = rr_pick(~vpu_empty_s, ~ll_empty_s, rr_r);
    assign head_sel_s = (winner_s == LL) ? ll_head_s : vpu_head_s;
    // Stall depends only on registered state, never on the pipe inputs
    assign stall_s    = (starve_cnt_r == STARVE_MAX) & any_q_s;

    // Port selection: forced drain, then pipeline, then opportunistic drain
    always_comb begin
        sel_valid_s = 1'b0;
        pop_s       = 1'b0;
        sel_req_s   = {WB_REQ_W{1'b0}};
        if (stall_s) begin
            sel_valid_s = 1'b1;
            pop_s       = 1'b1;
            sel_req_s   = head_sel_s;
        end else if (pipe_valid_i) begin
            sel_valid_s = 1'b1;
            sel_req_s   = '{fpr: pipe_fpr_i, rd: pipe_rd_i, data: pipe_data_i};
        end else if (any_q_s) begin
            sel_valid_s = 1'b1;
            pop_s       = 1'b1;
            sel_req_s   = head_sel_s;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    assign vpu_pop_s    = pop_s & (winner_s == VPU);
    assign ll_pop_s     = pop_s & (winner_s == LL);

    assign stall_o      = stall_s;
    assign rd_web_o     = sel_valid_s & ~sel_req_s.fpr & (sel_req_s.rd != 5'd0);
    assign frd_web_o    = sel_valid_s & sel_req_s.fpr;
    assign rd_o         = sel_req_s.rd;
    assign data_o       = sel_req_s.data;
    assign ll_pending_o = any_q_s;

    // Round-robin pointer hands priority to the other queue after each pop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_r <= VPU;
        end else if (vpu_pop_s) begin
            rr_r <= LL;
        end else if (ll_pop_s) begin
            rr_r <= VPU;
        end else begin
            rr_r <= rr_r;
        end
    end

    // Starvation counter: cycles a waiting entry lost the port to the pipeline
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (pop_s || !any_q_s) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (pipe_valid_i && (starve_cnt_r != STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + CNT_ONE;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    wb_port_arbiter_chk #(.QDEPTH(QDEPTH)) u_chk (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pipe_valid   (pipe_valid_i),
        .pipe_fpr     (pipe_fpr_i),
        .pipe_rd      (pipe_rd_i),
        .vpu_slots    (vpu_slots_s),
        .vpu_slot_vld (vpu_slot_vld_s),
        .ll_slots     (ll_slots_s),
        .ll_slot_vld  (ll_slot_vld_s)
    );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: stimulus pushes hand-computed expected
// writes into a scoreboard; a negedge monitor compares every presented write.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pipe_valid_i, pipe_fpr_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_data_i;
    logic        vpu_valid_i, vpu_ready_o, vpu_fpr_i;
    logic [4:0]  vpu_rd_i;
    logic [31:0] vpu_data_i;
    logic        ll_valid_i, ll_ready_o, ll_fpr_i;
    logic [4:0]  ll_rd_i;
    logic [31:0] ll_data_i;
    logic        stall_o, rd_web_o, frd_web_o, ll_pending_o;
    logic [4:0]  rd_o;
    logic [31:0] data_o;

    always #5 clk_i = ~clk_i;

    wb_port_arbiter #(.QDEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pipe_valid_i(pipe_valid_i), .pipe_fpr_i(pipe_fpr_i),
        .pipe_rd_i(pipe_rd_i), .pipe_data_i(pipe_data_i),
        .vpu_valid_i(vpu_valid_i), .vpu_ready_o(vpu_ready_o), .vpu_fpr_i(vpu_fpr_i),
        .vpu_rd_i(vpu_rd_i), .vpu_data_i(vpu_data_i),
        .ll_valid_i(ll_valid_i), .ll_ready_o(ll_ready_o), .ll_fpr_i(ll_fpr_i),
        .ll_rd_i(ll_rd_i), .ll_data_i(ll_data_i),
        .stall_o(stall_o), .rd_web_o(rd_web_o), .frd_web_o(frd_web_o),
        .rd_o(rd_o), .data_o(data_o), .ll_pending_o(ll_pending_o)
    );

    typedef struct {
        logic        iwe;
        logic        fwe;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        stl;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t ew(input logic fpr, input logic [4:0] rd,
                                input logic [31:0] d, input logic stl);
        exp_t e;
        e.iwe  = !fpr && (rd != 5'd0);
        e.fwe  = fpr;
        e.rd   = rd;
        e.data = d;
        e.stl  = stl;
        return e;
    endfunction

    // Monitor: every cycle that writes or stalls consumes one expected entry
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && (rd_web_o || frd_web_o || stall_o)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got we=%0b fwe=%0b stall=%0b rd=%0d data=0x%0h expected none",
                         rd_web_o, frd_web_o, stall_o, rd_o, data_o);
            end else begin
                e = exp_q.pop_front();
                chk("wr_rd_web",  32'(rd_web_o),  32'(e.iwe));
                chk("wr_frd_web", 32'(frd_web_o), 32'(e.fwe));
                chk("wr_rd",      32'(rd_o),      32'(e.rd));
                chk("wr_data",    data_o,         e.data);
                chk("wr_stall",   32'(stall_o),   32'(e.stl));
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        pipe_valid_i = 1'b0; pipe_fpr_i = 1'b0; pipe_rd_i = 5'd0; pipe_data_i = 32'd0;
        vpu_valid_i  = 1'b0; vpu_fpr_i  = 1'b0; vpu_rd_i  = 5'd0; vpu_data_i  = 32'd0;
        ll_valid_i   = 1'b0; ll_fpr_i   = 1'b0; ll_rd_i   = 5'd0; ll_data_i   = 32'd0;
    endtask

    task automatic set_vpu(input logic fpr, input logic [4:0] rd, input logic [31:0] d);
        vpu_valid_i = 1'b1; vpu_fpr_i = fpr; vpu_rd_i = rd; vpu_data_i = d;
    endtask

    task automatic set_ll(input logic fpr, input logic [4:0] rd, input logic [31:0] d);
        ll_valid_i = 1'b1; ll_fpr_i = fpr; ll_rd_i = rd; ll_data_i = d;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((ll_pending_o || exp_q.size() != 0) && n < 50) begin
            step();
            n++;
        end
        chk({name, "_drain_in_time"}, 32'(n < 50), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k, cyc, stall_n, stall_at;
        logic stl;

        idle_all();
        rst_i = 1'b1;
        repeat (3) step();
        rst_i = 1'b0;

        // Reset / idle state
        @(negedge clk_i);
        chk("rst_rd_web",     32'(rd_web_o),     32'd0);
        chk("rst_frd_web",    32'(frd_web_o),    32'd0);
        chk("rst_rd",         32'(rd_o),         32'd0);
        chk("rst_data",       data_o,            32'd0);
        chk("rst_stall",      32'(stall_o),      32'd0);
        chk("rst_pending",    32'(ll_pending_o), 32'd0);
        chk("rst_vpu_ready",  32'(vpu_ready_o),  32'd1);
        chk("rst_ll_ready",   32'(ll_ready_o),   32'd1);
        step();

        // Single LL push with idle pipe: written next cycle, empty after
        set_ll(1'b0, 5'd5, 32'h1234);
        exp_q.push_back(ew(1'b0, 5'd5, 32'h1234, 1'b0));
        step();
        idle_all();
        @(negedge clk_i);
        chk("ll_single_pending", 32'(ll_pending_o), 32'd1);
        step();
        @(negedge clk_i);
        chk("ll_single_empty_after", 32'(ll_pending_o), 32'd0);
        step();

        // Simultaneous pair -> VPU then LL
        set_vpu(1'b0, 5'd3, 32'hA1);
        set_ll (1'b1, 5'd4, 32'hB1);
        exp_q.push_back(ew(1'b0, 5'd3, 32'hA1, 1'b0));
        exp_q.push_back(ew(1'b1, 5'd4, 32'hB1, 1'b0));
        step();
        idle_all();
        wait_drain("pair1");

        // Lone VPU entry, leaving priority with LL
        set_vpu(1'b0, 5'd6, 32'hC1);
        exp_q.push_back(ew(1'b0, 5'd6, 32'hC1, 1'b0));
        step();
        idle_all();
        wait_drain("vpu_lone");

        // Second simultaneous pair -> LL then VPU
        set_vpu(1'b0, 5'd8, 32'hA2);
        set_ll (1'b0, 5'd9, 32'hB2);
        exp_q.push_back(ew(1'b0, 5'd9, 32'hB2, 1'b0));
        exp_q.push_back(ew(1'b0, 5'd8, 32'hA2, 1'b0));
        step();
        idle_all();
        wait_drain("pair2");

        // Starvation: LL queued under a busy pipe; stall on the 9th waiting cycle
        for (int i = 0; i < 9; i++) exp_q.push_back(ew(1'b0, 5'(10 + i), 32'h5000 + 32'(i), 1'b0));
        exp_q.push_back(ew(1'b0, 5'd7, 32'h77, 1'b1));
        for (int i = 9; i < 20; i++) exp_q.push_back(ew(1'b0, 5'(10 + i), 32'h5000 + 32'(i), 1'b0));
        k = 0; cyc = 0; stall_n = 0; stall_at = -1;
        while (k < 20 && cyc < 60) begin
            pipe_valid_i = 1'b1; pipe_fpr_i = 1'b0;
            pipe_rd_i = 5'(10 + k); pipe_data_i = 32'h5000 + 32'(k);
            if (cyc == 0) set_ll(1'b0, 5'd7, 32'h77);
            else ll_valid_i = 1'b0;
            @(negedge clk_i);
            stl = stall_o;
            if (stl) begin
                stall_n++;
                stall_at = cyc;
            end
            step();
            if (!stl) k++;
            cyc++;
        end
        idle_all();
        chk("starve_loop_done",   32'(cyc < 60), 32'd1);
        chk("starve_stall_count", 32'(stall_n),  32'd1);
        chk("starve_stall_cycle", 32'(stall_at), 32'd9);
        wait_drain("starve");

        // Fill the VPU queue under a busy pipe; a third valid is held
        for (int i = 0; i < 4; i++) exp_q.push_back(ew(1'b0, 5'(20 + i), 32'h6000 + 32'(i), 1'b0));
        exp_q.push_back(ew(1'b0, 5'd1,  32'hAA, 1'b0));
        exp_q.push_back(ew(1'b0, 5'd2,  32'hBB, 1'b0));
        exp_q.push_back(ew(1'b0, 5'd11, 32'hCC, 1'b0));
        for (int i = 0; i < 4; i++) begin
            pipe_valid_i = 1'b1; pipe_fpr_i = 1'b0;
            pipe_rd_i = 5'(20 + i); pipe_data_i = 32'h6000 + 32'(i);
            if (i == 0) set_vpu(1'b0, 5'd1, 32'hAA);
            else if (i == 1) set_vpu(1'b0, 5'd2, 32'hBB);
            else set_vpu(1'b0, 5'd11, 32'hCC);
            if (i >= 2) begin
                @(negedge clk_i);
                chk("vpu_full_ready", 32'(vpu_ready_o), 32'd0);
            end
            step();
        end
        pipe_valid_i = 1'b0;
        @(negedge clk_i);
        chk("vpu_ready_during_pop", 32'(vpu_ready_o), 32'd0);
        step();
        @(negedge clk_i);
        chk("vpu_ready_after_pop", 32'(vpu_ready_o), 32'd1);
        step();
        idle_all();
        wait_drain("vpu_fill");

        // rd=0 integer entry is discarded, FP rd=0 is written
        set_ll(1'b0, 5'd0, 32'h55);
        exp_q.push_back(ew(1'b1, 5'd0, 32'hDEAD, 1'b0));
        step();
        set_ll(1'b1, 5'd0, 32'hDEAD);
        @(negedge clk_i);
        chk("rd0_no_int_we", 32'(rd_web_o),  32'd0);
        chk("rd0_no_fp_we",  32'(frd_web_o), 32'd0);
        step();
        idle_all();
        wait_drain("rd0");

        // Reset mid-operation discards queued entries
        pipe_valid_i = 1'b1; pipe_rd_i = 5'd30; pipe_data_i = 32'h9000;
        set_vpu(1'b0, 5'd12, 32'h99);
        exp_q.push_back(ew(1'b0, 5'd30, 32'h9000, 1'b0));
        step();
        idle_all();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("midrst_pending",   32'(ll_pending_o), 32'd0);
        chk("midrst_vpu_ready", 32'(vpu_ready_o),  32'd1);
        chk("midrst_rd_web",    32'(rd_web_o),     32'd0);
        step();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
